// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, word geometry
// and the wait-state counter width helper.
package dmem_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int BYTES_PER_WORD = 4;

  // Default wait-state count and the counter width that goes with it
  localparam int WAIT_CYCLES_DEFAULT = 2;
  localparam int CNT_W_DEFAULT =
    ($clog2(WAIT_CYCLES_DEFAULT + 1) < 1) ? 1 : $clog2(WAIT_CYCLES_DEFAULT + 1);

  // Counter width for a given wait-state count; never narrower than one bit
  function automatic int dmem_cnt_width(input int wait_cycles);
    int w;
    w = $clog2(wait_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store bus between the datapath (master) and the data memory (slave):
// a request channel and a response channel, each with valid/ready.
interface dmem_responder_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port word array with per-byte write enables and a registered read.
// Contents are deliberately not reset so stored data survives a responder reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DW      = 32,
  parameter int DEPTH_W = 6
) (
  input  logic               clk,
  input  logic               en,
  input  logic               we,
  input  logic [3:0]         be,
  input  logic [DEPTH_W-1:0] addr,
  input  logic [DW-1:0]      wdata,
  output logic [DW-1:0]      rdata
);

  logic [DW-1:0] mem_r [2**DEPTH_W];
  logic [DW-1:0] rdata_r;

  // Byte-masked write or word read; rdata only changes on an enabled read
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
          if (be[i]) begin
            mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata_r <= mem_r[addr];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES,
// accesses the byte-enabled array, then holds the response until taken.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int Data_Width        = 32,
  parameter int Address_Width_RAM = 8,
  parameter int WAIT_CYCLES       = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam int CNT_W = dmem_cnt_width(WAIT_CYCLES);
  localparam int AW    = Address_Width_RAM;

  dmem_state_e           state_r, state_next_s;
  logic [CNT_W-1:0]      cnt_r, cnt_next_s;
  logic                  hold_we_r;
  logic [AW-1:0]         hold_addr_r;
  logic [Data_Width-1:0] hold_wdata_r;
  logic [3:0]            hold_be_r;
  logic                  req_ready_r;
  logic                  rsp_valid_r;
  logic                  rsp_err_r, rsp_err_next_s;
  logic                  load_ok_r, load_ok_next_s;
  logic                  capture_s;
  logic                  access_s;
  logic                  misaligned_s;
  logic [Data_Width-1:0] arr_rdata_s;

  assign misaligned_s = (hold_addr_r[1:0] != 2'b00);

  // Next-state, counter and response-flag decode
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    rsp_err_next_s = rsp_err_r;
    load_ok_next_s = load_ok_r;
    capture_s      = 1'b0;
    access_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          capture_s      = 1'b1;
          cnt_next_s     = CNT_W'(WAIT_CYCLES);
          rsp_err_next_s = 1'b0;
          load_ok_next_s = 1'b0;
          state_next_s   = WAIT;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r != {CNT_W{1'b0}}) begin
          cnt_next_s = cnt_r - CNT_W'(1);
        end else begin
          access_s       = 1'b1;
          rsp_err_next_s = misaligned_s;
          load_ok_next_s = ~hold_we_r & ~misaligned_s;
          state_next_s   = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_err_next_s = 1'b0;
          load_ok_next_s = 1'b0;
          state_next_s   = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        rsp_err_next_s = 1'b0;
        load_ok_next_s = 1'b0;
        state_next_s   = IDLE;
      end
    endcase
  end

  // State, counter and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      load_ok_r   <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      req_ready_r <= (state_next_s == IDLE);
      rsp_valid_r <= (state_next_s == RESP);
      rsp_err_r   <= rsp_err_next_s;
      load_ok_r   <= load_ok_next_s;
    end
  end

  // Request holding registers; later request changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_we_r    <= 1'b0;
      hold_addr_r  <= {AW{1'b0}};
      hold_wdata_r <= {Data_Width{1'b0}};
      hold_be_r    <= 4'b0000;
    end else if (capture_s) begin
      hold_we_r    <= bus.req_we;
      hold_addr_r  <= bus.req_addr;
      hold_wdata_r <= bus.req_wdata;
      hold_be_r    <= bus.req_be;
    end
  end

  dmem_array #(
    .DW      (Data_Width),
    .DEPTH_W (AW - 2)
  ) u_array (
    .clk   (clk),
    .en    (access_s & ~misaligned_s),
    .we    (hold_we_r),
    .be    (hold_be_r),
    .addr  (hold_addr_r[AW-1:2]),
    .wdata (hold_wdata_r),
    .rdata (arr_rdata_s)
  );

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = rsp_err_r;
  // Registered array data is exposed only for a good load, otherwise zero
  assign bus.rsp_rdata = load_ok_r ? arr_rdata_s : {Data_Width{1'b0}};

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a driver issues requests and queues the
// expected response from a word-array reference model; a monitor checks
// latency, hold stability and data whenever a response is presented.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int WC = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if #(.AW(AW), .DW(DW)) bus ();
  dmem_responder_if #(.AW(AW), .DW(DW)) bus0 ();

  dmem_responder #(.Data_Width(DW), .Address_Width_RAM(AW), .WAIT_CYCLES(WC)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  dmem_responder #(.Data_Width(DW), .Address_Width_RAM(AW), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          rsp_mode = 0;
  exp_t        sb_q[$];
  logic [31:0] mdl [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference behaviour: word-indexed array, misaligned means no access
  task automatic apply_model(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, output logic [31:0] rd, output logic err);
    int idx;
    idx = addr / 4;
    rd  = 32'h0;
    err = (addr % 4) != 0;
    if (!err) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mdl[idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        rd = mdl[idx];
      end
    end
  endtask

  task automatic issue(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input bit push);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) begin
      fail("req_ready_timeout");
    end else begin
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_be    = be;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'($urandom_range(0, 1));
      bus.req_addr  = 8'($urandom);
      bus.req_wdata = $urandom;
      bus.req_be    = 4'($urandom);
      if (push) begin
        apply_model(we, addr, wdata, be, e.rdata, e.err);
        e.acc = cyc;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0) fail("drain_timeout");
    @(negedge clk);
    @(negedge clk);
  endtask

  // Cycle counter for latency measurement
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response-channel backpressure generator
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rsp_mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = 1'($urandom_range(0, 1));
        default: bus.rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: latency, stability while held, data on handshake, post-handshake state
  initial begin
    logic        prev_valid;
    logic        hs_pending;
    logic [31:0] held_rdata;
    logic        held_err;
    exp_t        e;
    prev_valid = 1'b0;
    hs_pending = 1'b0;
    held_rdata = 32'h0;
    held_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        hs_pending = 1'b0;
      end else begin
        if (hs_pending) begin
          check("post_hs_rsp_valid", 32'(bus.rsp_valid), 32'h0);
          check("post_hs_req_ready", 32'(bus.req_ready), 32'h1);
          hs_pending = 1'b0;
        end
        if (bus.rsp_valid) begin
          check("busy_req_ready", 32'(bus.req_ready), 32'h0);
          if (!prev_valid) begin
            if (sb_q.size() == 0) fail("unexpected_rsp");
            else check("latency", 32'(cyc - sb_q[0].acc), 32'(WC + 1));
            held_rdata = bus.rsp_rdata;
            held_err   = bus.rsp_err;
          end else begin
            check("hold_rdata", bus.rsp_rdata, held_rdata);
            check("hold_err", 32'(bus.rsp_err), 32'(held_err));
          end
          if (bus.rsp_ready) begin
            if (sb_q.size() == 0) begin
              fail("rsp_without_expect");
            end else begin
              e = sb_q.pop_front();
              check("rsp_rdata", bus.rsp_rdata, e.rdata);
              check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end
            hs_pending = 1'b1;
          end
        end
        prev_valid = bus.rsp_valid;
      end
    end
  end

  initial begin
    int   t;
    logic we;
    logic [7:0] addr;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 8'h0;
    bus.req_wdata = 32'h0; bus.req_be = 4'h0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = 8'h0;
    bus0.req_wdata = 32'h0; bus0.req_be = 4'h0; bus0.rsp_ready = 1'b1;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'h1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'h0);

    // Zero-wait build: response one edge after acceptance (misaligned load)
    bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_addr = 8'h02;
    @(posedge clk);
    #1 bus0.req_valid = 1'b0;
    @(negedge clk);
    check("wc0_valid_after_e0", 32'(bus0.rsp_valid), 32'h0);
    @(negedge clk);
    check("wc0_valid_after_e1", 32'(bus0.rsp_valid), 32'h1);
    check("wc0_err", 32'(bus0.rsp_err), 32'h1);
    check("wc0_rdata", bus0.rsp_rdata, 32'h0);
    @(negedge clk);
    check("wc0_done_valid", 32'(bus0.rsp_valid), 32'h0);
    check("wc0_done_ready", 32'(bus0.req_ready), 32'h1);

    // Preload every word so the model is fully defined; 0x30 holds zero
    for (int i = 0; i < 64; i++)
      issue(1'b1, 8'(i * 4), (i == 12) ? 32'h0 : $urandom, 4'hF, 1'b1);

    // Directed: full store/load, partial store, misaligned, empty byte mask
    issue(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    issue(1'b0, 8'h10, 32'h0, 4'h0, 1'b1);
    issue(1'b1, 8'h20, 32'h11223344, 4'hF, 1'b1);
    issue(1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, 1'b1);
    issue(1'b0, 8'h20, 32'h0, 4'h0, 1'b1);
    issue(1'b0, 8'h22, 32'h0, 4'h0, 1'b1);
    issue(1'b1, 8'h21, 32'h55667788, 4'hF, 1'b1);
    issue(1'b0, 8'h20, 32'h0, 4'h0, 1'b1);
    issue(1'b1, 8'h24, 32'h99999999, 4'b0000, 1'b1);
    issue(1'b0, 8'h24, 32'h0, 4'h0, 1'b1);
    wait_drain();

    // Backpressure: response held for several cycles, then released
    rsp_mode = 2;
    issue(1'b0, 8'h10, 32'h0, 4'h0, 1'b1);
    t = 0;
    while (!bus.rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rsp_valid) fail("bp_rsp_timeout");
    repeat (5) begin
      @(negedge clk);
      check("bp_valid_held", 32'(bus.rsp_valid), 32'h1);
    end
    rsp_mode = 0;
    wait_drain();

    // Reset while a store waits: outputs clear at once, store discarded
    issue(1'b1, 8'h30, 32'hCAFEF00D, 4'hF, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 32'(bus.req_ready), 32'h1);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("midrst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("midrst_rsp_err", 32'(bus.rsp_err), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(1'b0, 8'h30, 32'h0, 4'h0, 1'b1);
    wait_drain();

    // Random traffic with random backpressure
    rsp_mode = 1;
    for (int i = 0; i < 150; i++) begin
      we   = 1'($urandom_range(0, 1));
      addr = 8'($urandom);
      if ($urandom_range(0, 7) != 0) addr[1:0] = 2'b00;
      issue(we, addr, $urandom, 4'($urandom), 1'b1);
    end
    rsp_mode = 0;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
